// File: rtl/l2_tlb_arbiter.sv
// rtl/l2_tlb_arbiter.sv - sequencer/arbiter for the shared 64-entry L2 TLB query and write ports
module l2_tlb_arbiter #(
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_vaddr,
    output logic        ireq_ack,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_vaddr,
    output logic        dreq_ack,
    input  logic        tlbp_req,
    input  logic        tlbw_req,
    input  logic        tlbw_random,
    output logic        iresp_valid,
    output logic        dresp_valid,
    output logic        tlbp_done,
    output logic        tlbw_done,
    output logic [78:0] resp_tlb,
    output logic        resp_hit,
    output logic [5:0]  resp_index,
    output logic        timeout_err,
    output logic        l2_qry_en,
    output logic [31:0] l2_qry_vaddr,
    output logic        l2_qry_useentryhi,
    output logic        l2_tlbwi_en,
    output logic        l2_tlbwr_en,
    input  logic [78:0] l2_qry_tlb,
    input  logic        l2_qry_isexist,
    input  logic [5:0]  l2_qry_index,
    input  logic        l2_qry_done
);

    typedef enum logic [2:0] {S_IDLE, S_BUSY, S_RESP, S_WRITE, S_WSETTLE} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_P    = 2'd3;
    localparam logic [7:0] TMO      = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        rr_q, rr_d;          // 1: D wins the next I/D tie
    logic        cancel_q, cancel_d;  // flush seen since the current I/D grant
    logic [7:0]  cnt_q, cnt_d;

    logic        ireq_ack_q, ireq_ack_d, dreq_ack_q, dreq_ack_d;
    logic        iresp_q, iresp_d, dresp_q, dresp_d;
    logic        tlbp_done_q, tlbp_done_d, tlbw_done_q, tlbw_done_d;
    logic [78:0] resp_tlb_q, resp_tlb_d;
    logic        resp_hit_q, resp_hit_d;
    logic [5:0]  resp_index_q, resp_index_d;
    logic        timeout_q, timeout_d;
    logic        qry_en_q, qry_en_d;
    logic [31:0] qry_vaddr_q, qry_vaddr_d;
    logic        useentryhi_q, useentryhi_d;
    logic        tlbwi_q, tlbwi_d, tlbwr_q, tlbwr_d;

    // RESP doubles as an arbitration cycle so back-to-back queries reach 12-cycle throughput
    logic arb_en, i_ok, d_ok, gnt_w, gnt_p, gnt_i, gnt_d, gnt_q, done_hit, tmo_hit, cancel_now;
    assign arb_en     = (state_q == S_IDLE) || (state_q == S_RESP);
    assign i_ok       = ireq_valid & ~flush;
    assign d_ok       = dreq_valid & ~flush;
    assign gnt_w      = arb_en & tlbw_req;
    assign gnt_p      = arb_en & ~tlbw_req & tlbp_req;
    assign gnt_d      = arb_en & ~tlbw_req & ~tlbp_req & d_ok & (~i_ok | rr_q);
    assign gnt_i      = arb_en & ~tlbw_req & ~tlbp_req & i_ok & (~d_ok | ~rr_q);
    assign gnt_q      = gnt_p | gnt_d | gnt_i;
    assign done_hit   = (state_q == S_BUSY) && l2_qry_done;
    assign tmo_hit    = (state_q == S_BUSY) && !l2_qry_done && (cnt_q == TMO);
    assign cancel_now = cancel_q | flush;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (gnt_w)      state_d = S_WRITE;
                else if (gnt_q) state_d = S_BUSY;
                else            state_d = S_IDLE;
            end
            S_BUSY:    if (done_hit || tmo_hit) state_d = S_RESP;
            S_WRITE:   state_d = S_WSETTLE;
            S_WSETTLE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and bookkeeping next values
    always_comb begin
        owner_d      = owner_q;
        rr_d         = rr_q;
        cancel_d     = cancel_q;
        cnt_d        = cnt_q;
        ireq_ack_d   = 1'b0;
        dreq_ack_d   = 1'b0;
        iresp_d      = 1'b0;
        dresp_d      = 1'b0;
        tlbp_done_d  = 1'b0;
        tlbw_done_d  = (state_q == S_WSETTLE);
        resp_tlb_d   = resp_tlb_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        timeout_d    = 1'b0;
        qry_en_d     = 1'b0;
        qry_vaddr_d  = qry_vaddr_q;
        useentryhi_d = useentryhi_q;
        tlbwi_d      = 1'b0;
        tlbwr_d      = 1'b0;
        if (gnt_w) begin
            tlbwr_d = tlbw_random;
            tlbwi_d = ~tlbw_random;
        end else if (gnt_q) begin
            qry_en_d     = 1'b1;
            useentryhi_d = gnt_p;
            cnt_d        = 8'd0;
            cancel_d     = 1'b0;
            if (gnt_p) begin
                owner_d     = OWN_P;
                qry_vaddr_d = 32'd0;
            end else if (gnt_d) begin
                owner_d     = OWN_D;
                qry_vaddr_d = dreq_vaddr;
                dreq_ack_d  = 1'b1;
                rr_d        = 1'b0;
            end else begin
                owner_d     = OWN_I;
                qry_vaddr_d = ireq_vaddr;
                ireq_ack_d  = 1'b1;
                rr_d        = 1'b1;
            end
        end
        if (state_q == S_BUSY) begin
            cnt_d    = cnt_q + 8'd1;
            cancel_d = cancel_now;
            if (done_hit || tmo_hit) begin
                if (done_hit) begin
                    resp_tlb_d   = l2_qry_tlb;
                    resp_hit_d   = l2_qry_isexist;
                    resp_index_d = l2_qry_index;
                end else begin
                    resp_tlb_d   = 79'd0;
                    resp_hit_d   = 1'b0;
                    resp_index_d = 6'd0;
                    timeout_d    = 1'b1;
                end
                case (owner_q)
                    OWN_I:   iresp_d     = ~cancel_now;
                    OWN_D:   dresp_d     = ~cancel_now;
                    OWN_P:   tlbp_done_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs and bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            rr_q         <= 1'b0;
            cancel_q     <= 1'b0;
            cnt_q        <= 8'd0;
            ireq_ack_q   <= 1'b0;
            dreq_ack_q   <= 1'b0;
            iresp_q      <= 1'b0;
            dresp_q      <= 1'b0;
            tlbp_done_q  <= 1'b0;
            tlbw_done_q  <= 1'b0;
            resp_tlb_q   <= 79'd0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= 6'd0;
            timeout_q    <= 1'b0;
            qry_en_q     <= 1'b0;
            qry_vaddr_q  <= 32'd0;
            useentryhi_q <= 1'b0;
            tlbwi_q      <= 1'b0;
            tlbwr_q      <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            cancel_q     <= cancel_d;
            cnt_q        <= cnt_d;
            ireq_ack_q   <= ireq_ack_d;
            dreq_ack_q   <= dreq_ack_d;
            iresp_q      <= iresp_d;
            dresp_q      <= dresp_d;
            tlbp_done_q  <= tlbp_done_d;
            tlbw_done_q  <= tlbw_done_d;
            resp_tlb_q   <= resp_tlb_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
            timeout_q    <= timeout_d;
            qry_en_q     <= qry_en_d;
            qry_vaddr_q  <= qry_vaddr_d;
            useentryhi_q <= useentryhi_d;
            tlbwi_q      <= tlbwi_d;
            tlbwr_q      <= tlbwr_d;
        end
    end

    assign ireq_ack          = ireq_ack_q;
    assign dreq_ack          = dreq_ack_q;
    assign iresp_valid       = iresp_q;
    assign dresp_valid       = dresp_q;
    assign tlbp_done         = tlbp_done_q;
    assign tlbw_done         = tlbw_done_q;
    assign resp_tlb          = resp_tlb_q;
    assign resp_hit          = resp_hit_q;
    assign resp_index        = resp_index_q;
    assign timeout_err       = timeout_q;
    assign l2_qry_en         = qry_en_q;
    assign l2_qry_vaddr      = qry_vaddr_q;
    assign l2_qry_useentryhi = useentryhi_q;
    assign l2_tlbwi_en       = tlbwi_q;
    assign l2_tlbwr_en       = tlbwr_q;

endmodule

// File: tb/tb_l2_tlb_arbiter.sv
// tb/tb_l2_tlb_arbiter.sv - directed self-checking bench for l2_tlb_arbiter
module tb_l2_tlb_arbiter;

    localparam int TMO = 31;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ireq_valid = 1'b0;
    logic [31:0] ireq_vaddr = 32'd0;
    logic        dreq_valid = 1'b0;
    logic [31:0] dreq_vaddr = 32'd0;
    logic        tlbp_req = 1'b0;
    logic        tlbw_req = 1'b0;
    logic        tlbw_random = 1'b0;
    logic        ireq_ack, dreq_ack, iresp_valid, dresp_valid, tlbp_done, tlbw_done;
    logic [78:0] resp_tlb;
    logic        resp_hit;
    logic [5:0]  resp_index;
    logic        timeout_err, l2_qry_en, l2_qry_useentryhi, l2_tlbwi_en, l2_tlbwr_en;
    logic [31:0] l2_qry_vaddr;
    logic [78:0] l2_qry_tlb;
    logic        l2_qry_isexist;
    logic [5:0]  l2_qry_index;
    logic        l2_qry_done = 1'b0;

    int          checks = 0;
    int          errors = 0;

    // L2 TLB model state (written by the main process, read by the model)
    int          mdl_delay = 10;
    logic        mdl_exist = 1'b0;
    logic [5:0]  mdl_idx = 6'd0;
    logic [78:0] mdl_tlb = 79'd0;
    int          mdl_kick = 0;
    int          kick_seen = 0;
    int          mdl_cnt = 0;

    assign l2_qry_tlb     = mdl_tlb;
    assign l2_qry_isexist = mdl_exist;
    assign l2_qry_index   = mdl_idx;

    l2_tlb_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ireq_valid(ireq_valid), .ireq_vaddr(ireq_vaddr), .ireq_ack(ireq_ack),
        .dreq_valid(dreq_valid), .dreq_vaddr(dreq_vaddr), .dreq_ack(dreq_ack),
        .tlbp_req(tlbp_req), .tlbw_req(tlbw_req), .tlbw_random(tlbw_random),
        .iresp_valid(iresp_valid), .dresp_valid(dresp_valid),
        .tlbp_done(tlbp_done), .tlbw_done(tlbw_done),
        .resp_tlb(resp_tlb), .resp_hit(resp_hit), .resp_index(resp_index),
        .timeout_err(timeout_err), .l2_qry_en(l2_qry_en), .l2_qry_vaddr(l2_qry_vaddr),
        .l2_qry_useentryhi(l2_qry_useentryhi), .l2_tlbwi_en(l2_tlbwi_en),
        .l2_tlbwr_en(l2_tlbwr_en), .l2_qry_tlb(l2_qry_tlb),
        .l2_qry_isexist(l2_qry_isexist), .l2_qry_index(l2_qry_index),
        .l2_qry_done(l2_qry_done)
    );

    always #5 clk = ~clk;

    // L2 model: done pulse mdl_delay cycles after l2_qry_en (0 = never), or on a kick
    always @(negedge clk) begin
        l2_qry_done = 1'b0;
        if (reset) begin
            mdl_cnt = 0;
        end else begin
            if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) l2_qry_done = 1'b1;
            end
            if (l2_qry_en && mdl_delay > 0) mdl_cnt = mdl_delay;
            if (mdl_kick != kick_seen) begin
                kick_seen   = mdl_kick;
                l2_qry_done = 1'b1;
            end
        end
    end

    typedef struct {
        bit          is_d;
        logic [31:0] vaddr;
        int          delay;
        logic        exist;
        logic [5:0]  idx;
        logic [78:0] tlb;
        int          exp_resp;
    } vec_t;

    vec_t vt[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return ireq_ack;
            1: return dreq_ack;
            2: return iresp_valid;
            3: return dresp_valid;
            4: return tlbp_done;
            5: return tlbw_done;
            6: return l2_qry_en;
            7: return l2_tlbwi_en;
            8: return l2_tlbwr_en;
            9: return timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    // Ticks until signal w is high; n = ticks taken, or -1 when the budget expires
    task automatic wait_sig(input int w, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (sig(w)) begin
                n = k;
                break;
            end
        end
    endtask

    function automatic logic [49:0] flat_outs();
        return {ireq_ack, dreq_ack, iresp_valid, dresp_valid, tlbp_done, tlbw_done,
                resp_hit, resp_index, timeout_err, l2_qry_en, l2_qry_vaddr,
                l2_qry_useentryhi, l2_tlbwi_en, l2_tlbwr_en};
    endfunction

    initial begin
        int   n;
        int   cur;
        logic bad;

        vt[0] = '{1'b0, 32'h0040_2000, 10, 1'b1, 6'h2A, 79'h0ABC_DEF0_1234_5678, 12};
        vt[1] = '{1'b1, 32'h8000_1000, 10, 1'b0, 6'h00, 79'h0111_2222_3333_4444, 12};
        vt[2] = '{1'b1, 32'h1234_5678, 20, 1'b1, 6'h01, 79'h0F0F_0F0F_0F0F_0F0F, 22};
        vt[3] = '{1'b0, 32'hFFFF_F000, 3,  1'b1, 6'h3F, 79'h0000_0000_CAFE_BABE, 5};

        // Reset state
        tick();
        tick();
        chk("reset outputs", 128'(flat_outs()), 128'd0);
        chk("reset resp_tlb", 128'(resp_tlb), 128'd0);
        reset = 1'b0;
        tick();

        // Simultaneous I and D from reset: I first, D at 13
        mdl_delay = 10; mdl_exist = 1'b1; mdl_idx = 6'h05; mdl_tlb = 79'h55;
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_1000;
        dreq_valid = 1'b1; dreq_vaddr = 32'h0000_2000;
        cur = 0;
        wait_sig(0, 4, n); cur += n;
        chk("pair1 iack cycle", 128'(cur), 128'd1);
        chk("pair1 dack low at I grant", 128'(dreq_ack), 128'd0);
        chk("pair1 I vaddr", 128'(l2_qry_vaddr), 128'h1000);
        ireq_valid = 1'b0;
        wait_sig(2, 20, n); cur += n;
        chk("pair1 iresp cycle", 128'(cur), 128'd12);
        wait_sig(1, 4, n); cur += n;
        chk("pair1 dack cycle", 128'(cur), 128'd13);
        chk("pair1 D vaddr", 128'(l2_qry_vaddr), 128'h2000);
        dreq_valid = 1'b0;
        wait_sig(3, 20, n); cur += n;
        chk("pair1 dresp cycle", 128'(cur), 128'd24);
        tick(); tick();

        // Table of single queries
        for (int i = 0; i < 4; i++) begin
            mdl_delay = vt[i].delay; mdl_exist = vt[i].exist;
            mdl_idx = vt[i].idx; mdl_tlb = vt[i].tlb;
            if (vt[i].is_d) begin dreq_valid = 1'b1; dreq_vaddr = vt[i].vaddr; end
            else begin ireq_valid = 1'b1; ireq_vaddr = vt[i].vaddr; end
            cur = 0;
            wait_sig(vt[i].is_d ? 1 : 0, 4, n); cur += n;
            chk($sformatf("vec%0d ack cycle", i), 128'(cur), 128'd1);
            chk($sformatf("vec%0d qry_vaddr", i), 128'(l2_qry_vaddr), 128'(vt[i].vaddr));
            chk($sformatf("vec%0d useentryhi", i), 128'(l2_qry_useentryhi), 128'd0);
            ireq_valid = 1'b0; dreq_valid = 1'b0;
            wait_sig(vt[i].is_d ? 3 : 2, 40, n); cur += n;
            chk($sformatf("vec%0d resp cycle", i), 128'(cur), 128'(vt[i].exp_resp));
            chk($sformatf("vec%0d resp_hit", i), 128'(resp_hit), 128'(vt[i].exist));
            chk($sformatf("vec%0d resp_index", i), 128'(resp_index), 128'(vt[i].idx));
            chk($sformatf("vec%0d resp_tlb", i), 128'(resp_tlb), 128'(vt[i].tlb));
            tick(); tick();
        end

        // Last grant was I: next simultaneous pair goes D first
        mdl_delay = 10;
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_3000;
        dreq_valid = 1'b1; dreq_vaddr = 32'h0000_4000;
        cur = 0;
        wait_sig(1, 4, n); cur += n;
        chk("pair2 dack cycle", 128'(cur), 128'd1);
        chk("pair2 iack low at D grant", 128'(ireq_ack), 128'd0);
        dreq_valid = 1'b0;
        wait_sig(0, 20, n); cur += n;
        chk("pair2 iack cycle", 128'(cur), 128'd13);
        ireq_valid = 1'b0;
        wait_sig(2, 20, n); cur += n;
        chk("pair2 iresp cycle", 128'(cur), 128'd24);
        tick(); tick();

        // TLBW and TLBP arriving while a D query is busy
        dreq_valid = 1'b1; dreq_vaddr = 32'h0000_5000;
        cur = 0;
        wait_sig(1, 4, n); cur += n;
        dreq_valid = 1'b0;
        tick(); tick(); cur += 2;
        tlbw_req = 1'b1; tlbw_random = 1'b1; tlbp_req = 1'b1;
        wait_sig(3, 20, n); cur += n;
        chk("wr dresp cycle", 128'(cur), 128'd12);
        wait_sig(8, 4, n); cur += n;
        chk("wr tlbwr_en cycle", 128'(cur), 128'd13);
        chk("wr tlbwi_en low", 128'(l2_tlbwi_en), 128'd0);
        wait_sig(5, 6, n); cur += n;
        chk("wr tlbw_done cycle", 128'(cur), 128'd15);
        tlbw_req = 1'b0;
        wait_sig(6, 4, n); cur += n;
        chk("tlbp qry_en cycle", 128'(cur), 128'd16);
        chk("tlbp useentryhi", 128'(l2_qry_useentryhi), 128'd1);
        chk("tlbp qry_vaddr", 128'(l2_qry_vaddr), 128'd0);
        wait_sig(4, 20, n); cur += n;
        chk("tlbp_done cycle", 128'(cur), 128'd27);
        tlbp_req = 1'b0;
        tick(); tick();

        // Flush during an I query cancels its response and masks a new D request
        mdl_delay = 10; mdl_exist = 1'b1; mdl_idx = 6'h15; mdl_tlb = 79'h1234;
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_6000;
        cur = 0;
        wait_sig(0, 4, n); cur += n;
        ireq_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        cur += 4;
        flush = 1'b1; dreq_valid = 1'b1; dreq_vaddr = 32'h0000_7000;
        bad = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            bad = bad | iresp_valid | dreq_ack;
        end
        cur += 9;
        chk("flush no iresp/dack", 128'(bad), 128'd0);
        flush = 1'b0;
        wait_sig(1, 6, n); cur += n;
        chk("flush dack cycle", 128'(cur), 128'd15);
        dreq_valid = 1'b0;
        wait_sig(3, 20, n); cur += n;
        chk("flush dresp cycle", 128'(cur), 128'd26);
        chk("flush resp_index", 128'(resp_index), 128'h15);
        tick(); tick();

        // Timeout: L2 never answers, then a late done is ignored
        mdl_delay = 0;
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_8000;
        cur = 0;
        wait_sig(0, 4, n); cur += n;
        ireq_valid = 1'b0;
        wait_sig(9, 60, n); cur += n;
        chk("timeout cycle", 128'(cur), 128'(TMO + 2));
        chk("timeout iresp", 128'(iresp_valid), 128'd1);
        chk("timeout resp_hit", 128'(resp_hit), 128'd0);
        chk("timeout resp_index", 128'(resp_index), 128'd0);
        chk("timeout resp_tlb", 128'(resp_tlb), 128'd0);
        mdl_kick = mdl_kick + 1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            bad = bad | iresp_valid | dresp_valid | tlbp_done | timeout_err | resp_hit
                      | l2_qry_en;
        end
        chk("late done ignored", 128'(bad), 128'd0);

        // Asynchronous reset mid-BUSY, then a fresh query
        mdl_delay = 10; mdl_exist = 1'b1; mdl_idx = 6'h2A; mdl_tlb = 79'h77;
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_9000;
        wait_sig(0, 4, n);
        ireq_valid = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("async reset outputs", 128'(flat_outs()), 128'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        ireq_valid = 1'b1; ireq_vaddr = 32'h0000_A000;
        cur = 0;
        wait_sig(0, 4, n); cur += n;
        chk("post-reset iack cycle", 128'(cur), 128'd1);
        ireq_valid = 1'b0;
        wait_sig(2, 20, n); cur += n;
        chk("post-reset iresp cycle", 128'(cur), 128'd12);
        chk("post-reset resp_index", 128'(resp_index), 128'h2A);
        chk("post-reset resp_hit", 128'(resp_hit), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
